// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory port, redirect input and the
// decode-side valid/ready instruction stream, bundled for fetch_queue.
interface fetch_queue_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    // fetch_queue side
    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc
    );

    // memory / decode / redirect source side
    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues sequential word reads to a synchronous
// instruction memory, captures the returned word one cycle later into a
// DEPTH-entry FIFO and hands {pc, word} pairs to decode over valid/ready.
// A redirect flushes the FIFO and drops the in-flight read.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t        mem [0:DEPTH-1];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [31:0]   fetch_pc;
    logic [31:0]   pending_pc;
    logic          pending;

    logic [PW+1:0] occ;
    logic          issue;
    logic          push;
    logic          pop;
    logic          unused_rpc_lsbs;

    // The in-flight read reserves a slot, so the FIFO can never overflow.
    // A pop in this cycle is deliberately not credited to keep the path short.
    assign occ   = {1'b0, count} + (PW+2)'(pending);
    assign issue = occ < (PW+2)'(DEPTH);
    assign push  = pending && !bus.redirect_valid;
    assign pop   = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_data  = mem[rd_ptr].word;
    assign bus.inst_pc    = mem[rd_ptr].pc;

    // Redirect targets are word aligned; the low bits are dropped on purpose.
    assign unused_rpc_lsbs = ^bus.redirect_pc[1:0];

    // Fetch address, in-flight read tracking and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            pending  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            pending <= issue;
            if (issue) begin
                pending_pc <= fetch_pc;
                fetch_pc   <= fetch_pc + 32'd4;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // FIFO storage; contents are don't-care while not counted, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: pending_pc, word: bus.imem_rdata};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random traffic,
// every cycle checked against a queue-based model of the fetch stream.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC0  = 32'h0000_0000;
    localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fetch_queue_if bus ();
    fetch_queue_if bus1 ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );
    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC1)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: word at index i is (i<<20)|((i&31)<<7)|0x13
    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] i;
        i = a >> 2;
        return (i << 20) | ((i & 32'h1F) << 7) | 32'h13;
    endfunction

    // Synchronous instruction memories
    always @(posedge clk) begin
        bus.imem_rdata  <= word_of(bus.imem_addr);
        bus1.imem_rdata <= word_of(bus1.imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: queue of buffered PCs, one optional in-flight read,
    // next fetch address.
    logic [31:0] mq[$];
    bit          infl;
    logic [31:0] infl_pc;
    logic [31:0] mfpc;

    task automatic model_edge(input logic rn, input logic rv, input logic [31:0] rp,
                              input logic rdy);
        bit can_issue;
        if (!rn) begin
            mq.delete(); infl = 0; mfpc = RPC0;
        end else if (rv) begin
            mq.delete(); infl = 0; mfpc = rp & 32'hFFFF_FFFC;
        end else begin
            can_issue = (mq.size() + int'(infl)) < DEPTH;
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (infl) mq.push_back(infl_pc);
            if (can_issue) begin
                infl = 1; infl_pc = mfpc; mfpc = mfpc + 32'd4;
            end else begin
                infl = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("imem_addr", bus.imem_addr, mfpc);
        chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("inst_pc", bus.inst_pc, mq[0]);
            chk("inst_data", bus.inst_data, word_of(mq[0]));
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance model, check.
    task automatic cycle(input logic rn, input logic rv, input logic [31:0] rp,
                         input logic rdy);
        rst_n              = rn;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.inst_ready     = rdy;
        @(posedge clk);
        model_edge(rn, rv, rp, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    logic [31:0] wrap_pcs [0:2];

    initial begin
        checks = 0; failures = 0;
        mq.delete(); infl = 0; mfpc = RPC0; infl_pc = '0;
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b1;
        bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0; bus1.inst_ready = 1'b1;
        wrap_pcs[0] = 32'hFFFF_FFF8; wrap_pcs[1] = 32'hFFFF_FFFC; wrap_pcs[2] = 32'h0;
        @(negedge clk);

        // Reset state
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rst_addr", bus.imem_addr, RPC0);
        chk("rst_valid_wrap", {31'b0, bus1.inst_valid}, 32'd0);
        chk("rst_addr_wrap", bus1.imem_addr, RPC1);

        // Streaming from reset; wrap instance crosses 0xFFFFFFFC -> 0
        cycle(1, 0, 0, 1);
        chk("cyc1_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("cyc1_valid_wrap", {31'b0, bus1.inst_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 1);
            chk("stream_valid", {31'b0, bus.inst_valid}, 32'd1);
            chk("stream_pc", bus.inst_pc, 32'(k * 4));
            chk("wrap_valid", {31'b0, bus1.inst_valid}, 32'd1);
            chk("wrap_pc", bus1.inst_pc, wrap_pcs[k]);
            chk("wrap_data", bus1.inst_data, word_of(wrap_pcs[k]));
        end
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 1);

        // Backpressure: FIFO fills, fetch stops at 0x10
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 10; k++) cycle(1, 0, 0, 0);
        chk("stall_addr", bus.imem_addr, 32'h10);
        chk("stall_head", bus.inst_pc, 32'h0);
        for (int k = 0; k < 8; k++) cycle(1, 0, 0, 1);

        // Redirect with 3 buffered entries and a read in flight
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 0);
        cycle(1, 1, 32'h20, 0);
        chk("redir_n1_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("redir_n1_addr", bus.imem_addr, 32'h20);
        cycle(1, 0, 0, 1);
        chk("redir_n2_valid", {31'b0, bus.inst_valid}, 32'd0);
        cycle(1, 0, 0, 1);
        chk("redir_n3_pc", bus.inst_pc, 32'h20);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 1);

        // Misaligned redirect coinciding with a pop
        cycle(1, 1, 32'h23, 1);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        chk("redir23_pc", bus.inst_pc, 32'h20);
        chk("redir23_data", bus.inst_data, word_of(32'h20));
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 1);

        // Reset mid-stream with a full FIFO
        for (int k = 0; k < 7; k++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("midrst_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("midrst_addr", bus.imem_addr, RPC0);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        chk("midrst_pc", bus.inst_pc, RPC0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic        rn, rv, rdy;
            logic [31:0] rp;
            rn  = ($urandom_range(0, 99) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 4095));
            cycle(rn, rv, rp, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
